// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command constants and frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

    localparam int CNT_W = 20;

    // Bits after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// Command-side interface of the PS/2 host transmitter, including the FSM state for observation.
interface ps2_command_tx_if;
    import ps2_pkg::*;

    // send_cmd is a one-cycle request, taken only while busy is low (busy acts as not-ready);
    // cmd_byte is sampled with it. Each accepted request ends with exactly one cmd_sent or
    // cmd_error pulse, in the same cycle busy drops.
    logic          send_cmd;
    logic [7:0]    cmd_byte;
    logic          busy;
    logic          cmd_sent;
    logic          cmd_error;
    ps2_tx_state_t state;

    modport master (output send_cmd, cmd_byte, input busy, cmd_sent, cmd_error, state);
    modport slave  (input send_cmd, cmd_byte, output busy, cmd_sent, cmd_error, state);

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge strobe on clock.
module ps2_line_sync (
    input  logic inclock,
    input  logic resetn,
    input  logic clk_pin,
    input  logic dat_pin,
    output logic sync_clk,
    output logic sync_dat,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_pin};
            dat_ff   <= {dat_ff[0], dat_pin};
            clk_prev <= clk_ff[1];
        end
    end

    assign sync_clk = clk_ff[1];
    assign sync_dat = dat_ff[1];
    assign fall     = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter driving open-drain enables.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 750000
`endif
) (
    input  logic             inclock,
    input  logic             resetn,
    ps2_command_tx_if.slave  cmd,
    input  logic             ps2_clk_in,
    input  logic             ps2_dat_in,
    output logic             ps2_clk_oe,
    output logic             ps2_dat_oe
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt;
`endif

    ps2_tx_state_t    state;
    logic [9:0]       shreg;
    logic [3:0]       bitcnt;
    logic [CNT_W-1:0] inh_cnt;
    logic             busy;
    logic             sent;
    logic             err;
    logic             sync_clk;
    logic             sync_dat;
    logic             fall;

    ps2_line_sync u_sync (
        .inclock  (inclock),
        .resetn   (resetn),
        .clk_pin  (ps2_clk_in),
        .dat_pin  (ps2_dat_in),
        .sync_clk (sync_clk),
        .sync_dat (sync_dat),
        .fall     (fall)
    );

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            inh_cnt    <= '0;
            busy       <= 1'b0;
            sent       <= 1'b0;
            err        <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            sent <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.send_cmd) begin
                        shreg      <= tx_frame(cmd.cmd_byte);
                        bitcnt     <= '0;
                        inh_cnt    <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= ST_RTS;
                    end
                    if (inh_cnt != '1) inh_cnt <= inh_cnt + 1'b1;
                end
                ST_RTS: begin
                    ps2_clk_oe <= 1'b0;
                    state      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Start bit is already on the line, so fall 1 carries data bit 0.
                    if (fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        shreg      <= {1'b0, shreg[9:1]};
                        bitcnt     <= bitcnt + 1'b1;
                        if (bitcnt == 4'd9) state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (fall) begin
                        if (!sync_dat) begin
                            state <= ST_WAIT_IDLE;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (sync_clk && sync_dat) begin
                        sent  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog wins over anything the FSM decided this cycle.
            if (state == ST_IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_LAST) begin
                wd_cnt     <= '0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                sent       <= 1'b0;
                err        <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_IDLE;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

    assign cmd.busy      = busy;
    assign cmd.cmd_sent  = sent;
    assign cmd.cmd_error = err;
    assign cmd.state     = state;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: table of command transactions against a PS/2 device model,
// plus sequences for ignored requests, mid-transfer reset and a silent device.
module tb_ps2_command_tx;
    import ps2_pkg::*;

    localparam int H = 20;

    logic inclock = 1'b0;
    logic resetn;
    logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low, dev_dat_low;

    ps2_command_tx_if cmd_if ();

    ps2_command_tx dut (
        .inclock    (inclock),
        .resetn     (resetn),
        .cmd        (cmd_if),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 inclock = ~inclock;

    int checks = 0;
    int passed = 0;
    int sent_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_run = 0, last_inh = 0;

    typedef struct {
        logic [7:0]  cmd;
        bit          ack;
        logic [10:0] exp_frame;
        int          exp_sent;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Line levels as a device sees them: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge inclock) begin
        if (!resetn) inh_run = 0;
        else if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
        else begin
            if (ps2_clk_oe && ps2_dat_oe && inh_run != 0) last_inh = inh_run;
            inh_run = 0;
        end
        if (cmd_if.cmd_sent) sent_cnt++;
        if (cmd_if.cmd_error) err_cnt++;
        if (cmd_if.cmd_sent && cmd_if.cmd_error) both_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge inclock);
        cmd_if.send_cmd = 1'b1;
        cmd_if.cmd_byte = b;
        last_inh = 0;
        @(negedge inclock);
        cmd_if.send_cmd = 1'b0;
        check("busy_after_accept", 32'(cmd_if.busy), 32'd1);
    endtask

    // Device: waits for request-to-send, clocks 11 falls, samples each bit before the next fall.
    task automatic run_device(input bit ack, input int abort_fall, output logic [10:0] frame);
        int n = 0;
        frame = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 8000) begin
            @(negedge inclock);
            n++;
        end
        check("rts_seen", 32'(n < 8000), 32'd1);
        if (n >= 8000) return;
        repeat (H) @(negedge inclock);
        for (int k = 1; k <= 11; k++) begin
            frame[k-1] = ps2_dat_in;
            if (k == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge inclock);
            end
            dev_clk_low = 1'b1;
            if (k == abort_fall) begin
                repeat (5) @(negedge inclock);
                dev_clk_low = 1'b0;
                return;
            end
            repeat (H) @(negedge inclock);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge inclock);
            if (k == 11) dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (cmd_if.busy && n < 500) begin
            @(negedge inclock);
            n++;
        end
        check("busy_release", 32'(cmd_if.busy), 32'd0);
        repeat (5) @(negedge inclock);
    endtask

    initial begin
        logic [10:0] frame;
        int s0, e0, c;
        bit dropped;

        vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 11'h7DA, 1, 0};
        vecs[1] = '{PS2_CMD_RESET,   1'b1, 11'h7FE, 1, 0};
        vecs[2] = '{PS2_CMD_ENABLE,  1'b0, frame_model(PS2_CMD_ENABLE), 0, 1};
        for (int i = 3; i < 5; i++) begin
            vecs[i].cmd       = 8'($urandom_range(0, 255));
            vecs[i].ack       = 1'($urandom_range(0, 1));
            vecs[i].exp_frame = frame_model(vecs[i].cmd);
            vecs[i].exp_sent  = vecs[i].ack ? 1 : 0;
            vecs[i].exp_err   = vecs[i].ack ? 0 : 1;
        end

        resetn = 1'b0;
        cmd_if.send_cmd = 1'b0;
        cmd_if.cmd_byte = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge inclock);
        check("reset_outputs", {29'd0, ps2_clk_oe, ps2_dat_oe, cmd_if.busy}, 32'd0);
        check("reset_pulses", {30'd0, cmd_if.cmd_sent, cmd_if.cmd_error}, 32'd0);
        check("reset_state", 32'(cmd_if.state), 32'(ST_IDLE));
        resetn = 1'b1;
        repeat (4) @(negedge inclock);

        for (int i = 0; i < 5; i++) begin
            s0 = sent_cnt;
            e0 = err_cnt;
            send_byte(vecs[i].cmd);
            run_device(vecs[i].ack, 0, frame);
            wait_not_busy();
            check($sformatf("frame_%0d", i), 32'(frame), 32'(vecs[i].exp_frame));
            check($sformatf("inhibit_len_%0d", i), 32'(last_inh), 32'd6000);
            check($sformatf("sent_%0d", i), 32'(sent_cnt - s0), 32'(vecs[i].exp_sent));
            check($sformatf("error_%0d", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("released_%0d", i), {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        end

        // Request during SHIFT must be ignored.
        s0 = sent_cnt;
        send_byte(PS2_CMD_ENABLE);
        fork
            run_device(1'b1, 0, frame);
            begin
                repeat (6300) @(negedge inclock);
                cmd_if.send_cmd = 1'b1;
                cmd_if.cmd_byte = 8'h00;
                @(negedge inclock);
                cmd_if.send_cmd = 1'b0;
            end
        join
        wait_not_busy();
        check("ignored_req_frame", 32'(frame), 32'(frame_model(PS2_CMD_ENABLE)));
        check("ignored_req_sent", 32'(sent_cnt - s0), 32'd1);
        repeat (20) @(negedge inclock);
        check("ignored_req_idle", 32'(cmd_if.busy), 32'd0);

        // Reset after the 4th data fall, then a clean transfer.
        send_byte(PS2_CMD_SET_LED);
        run_device(1'b1, 4, frame);
        check("mid_reset_busy_before", 32'(cmd_if.busy), 32'd1);
        resetn = 1'b0;
        @(negedge inclock);
        check("mid_reset_released", {29'd0, ps2_clk_oe, ps2_dat_oe, cmd_if.busy}, 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge inclock);
        s0 = sent_cnt;
        e0 = err_cnt;
        send_byte(PS2_CMD_SET_LED);
        run_device(1'b1, 0, frame);
        wait_not_busy();
        check("post_reset_frame", 32'(frame), 32'h7DA);
        check("post_reset_sent", 32'(sent_cnt - s0), 32'd1);
        check("post_reset_error", 32'(err_cnt - e0), 32'd0);

        // Silent device.
        e0 = err_cnt;
        send_byte(PS2_CMD_RESET);
`ifdef PS2_TX_TIMEOUT_EN
        c = 0;
        while (!cmd_if.cmd_error && c < 800000) begin
            @(negedge inclock);
            c++;
        end
        check("timeout_latency", 32'(c), 32'd750000);
        @(negedge inclock);
        check("timeout_released", {29'd0, ps2_clk_oe, ps2_dat_oe, cmd_if.busy}, 32'd0);
        check("timeout_error_count", 32'(err_cnt - e0), 32'd1);
`else
        dropped = 1'b0;
        for (c = 0; c < 10000; c++) begin
            @(negedge inclock);
            if (!cmd_if.busy) dropped = 1'b1;
        end
        check("silent_busy_held", 32'(dropped), 32'd0);
        check("silent_no_error", 32'(err_cnt - e0), 32'd0);
        resetn = 1'b0;
        @(negedge inclock);
        resetn = 1'b1;
`endif

        check("never_both_pulses", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
